frame_receiver: RTL and testbench

- Receiving end of the serial frame link driven by the generator/FSM pair.
- Deserialises the one-bit stream (dynamic word first, then static word, MSB first) back into parallel words.
- Presents the words on DYNLATCH/STATLATCH with one-cycle strobes, and flags framing errors.
- Sits on the far side of the link, ahead of the consumer logic that uses the recovered words.

---
 rtl/frame_rx_pkg.sv | 26 ++
 rtl/rx_shift_reg.sv | 46 ++++
 rtl/frame_receiver.sv | 151 +++++++++++++++
 tb/tb_frame_receiver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/frame_rx_pkg.sv
// ============================================================================
// frame_rx_pkg: shared types and default frame geometry for the serial link.
// Revision: 1.0
// ============================================================================
`default_nettype none

package frame_rx_pkg;

  // Frame geometry shared with the generator side of the link
  localparam int SIZESRDYN_DEF  = 16;
  localparam int SIZESRSTAT_DEF = 88;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RX_DYN  = 2'd1,
    RX_STAT = 2'd2
  } rx_state_e;

  // Bit counter width, sized to hold the longer of the two words
  function automatic int cntw(input int dyn_w, input int stat_w);
    return $clog2(((dyn_w > stat_w) ? dyn_w : stat_w) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_shift_reg.sv
// ============================================================================
// rx_shift_reg: MSB-first serial-in/parallel-out shift register with clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rx_shift_reg
  import frame_rx_pkg::*;
#(
  parameter int WIDTH = SIZESRDYN_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             clear,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Clear applies first so a clear+shift loads the new bit into an empty register
  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end
    if (shift_en) begin
      q_d = {q_d[WIDTH-2:0], bit_in};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/frame_receiver.sv
// ============================================================================
// frame_receiver: deserialises dynamic+static frames, strobes words, counts aborts.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_receiver
  import frame_rx_pkg::*;
#(
  parameter int SIZESRDYN  = SIZESRDYN_DEF,
  parameter int SIZESRSTAT = SIZESRSTAT_DEF,
  parameter int ERRW       = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  signal_in,
  input  logic                  bit_valid,
  input  logic                  frame_start,
  output logic [SIZESRDYN-1:0]  DYNLATCH,
  output logic [SIZESRSTAT-1:0] STATLATCH,
  output logic                  dyn_valid,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [ERRW-1:0]       err_cnt,
  output logic                  busy
);

  localparam int CNTW = cntw(SIZESRDYN, SIZESRSTAT);

  rx_state_e             state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [SIZESRDYN-1:0]  dynlatch_q;
  logic [SIZESRSTAT-1:0] statlatch_q;
  logic                  dyn_valid_q, frame_valid_q, frame_err_q;
  logic [ERRW-1:0]       err_cnt_q;

  logic                  dyn_shift_d, dyn_clr_d, stat_shift_d, stat_clr_d;
  logic                  dyn_load_d, stat_load_d, err_d;
  logic [SIZESRDYN-1:0]  dyn_sr;
  logic [SIZESRSTAT-1:0] stat_sr;
  logic                  unused_msbs;

  rx_shift_reg #(.WIDTH(SIZESRDYN)) u_dyn_sr (
    .CLK      (CLK),
    .RST      (RST),
    .shift_en (dyn_shift_d),
    .bit_in   (signal_in),
    .clear    (dyn_clr_d),
    .q        (dyn_sr)
  );

  rx_shift_reg #(.WIDTH(SIZESRSTAT)) u_stat_sr (
    .CLK      (CLK),
    .RST      (RST),
    .shift_en (stat_shift_d),
    .bit_in   (signal_in),
    .clear    (stat_clr_d),
    .q        (stat_sr)
  );

  // The MSB of each register is shifted out on the completing beat, never read
  assign unused_msbs = dyn_sr[SIZESRDYN-1] ^ stat_sr[SIZESRSTAT-1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dyn_shift_d  = 1'b0;
    dyn_clr_d    = 1'b0;
    stat_shift_d = 1'b0;
    stat_clr_d   = 1'b0;
    dyn_load_d   = 1'b0;
    stat_load_d  = 1'b0;
    err_d        = 1'b0;
    if (bit_valid) begin
      if (frame_start) begin
        // Any start beat opens a new frame; mid-frame it also aborts the old one
        err_d       = (state_q != IDLE);
        dyn_clr_d   = 1'b1;
        dyn_shift_d = 1'b1;
        cnt_d       = CNTW'(1);
        state_d     = RX_DYN;
      end else begin
        case (state_q)
          RX_DYN: begin
            dyn_shift_d = 1'b1;
            if (cnt_q == CNTW'(SIZESRDYN - 1)) begin
              dyn_load_d = 1'b1;
              stat_clr_d = 1'b1;
              cnt_d      = '0;
              state_d    = RX_STAT;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
          RX_STAT: begin
            stat_shift_d = 1'b1;
            if (cnt_q == CNTW'(SIZESRSTAT - 1)) begin
              stat_load_d = 1'b1;
              cnt_d       = '0;
              state_d     = IDLE;
            end else begin
              cnt_d = cnt_q + CNTW'(1);
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dynlatch_q    <= '0;
      statlatch_q   <= '0;
      dyn_valid_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dyn_valid_q   <= dyn_load_d;
      frame_valid_q <= stat_load_d;
      frame_err_q   <= err_d;
      if (dyn_load_d) begin
        dynlatch_q <= {dyn_sr[SIZESRDYN-2:0], signal_in};
      end
      if (stat_load_d) begin
        statlatch_q <= {stat_sr[SIZESRSTAT-2:0], signal_in};
      end
      if (err_d && (err_cnt_q != {ERRW{1'b1}})) begin
        err_cnt_q <= err_cnt_q + ERRW'(1);
      end
    end
  end

  assign DYNLATCH    = dynlatch_q;
  assign STATLATCH   = statlatch_q;
  assign dyn_valid   = dyn_valid_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_frame_receiver.sv
// ============================================================================
// tb_frame_receiver: directed frame vectors plus abort/reset/saturation sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_receiver;

  localparam int DW = 16;
  localparam int SW = 88;
  localparam int EW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          signal_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [DW-1:0] DYNLATCH;
  logic [SW-1:0] STATLATCH;
  logic          dyn_valid, frame_valid, frame_err, busy;
  logic [EW-1:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int n_dv = 0, n_fv = 0, n_fe = 0;

  frame_receiver #(.SIZESRDYN(DW), .SIZESRSTAT(SW), .ERRW(EW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .signal_in   (signal_in),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .DYNLATCH    (DYNLATCH),
    .STATLATCH   (STATLATCH),
    .dyn_valid   (dyn_valid),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  // Each pulse is high for exactly one full cycle, so one negedge sees it once
  always @(negedge CLK) begin
    if (dyn_valid)   n_dv++;
    if (frame_valid) n_fv++;
    if (frame_err)   n_fe++;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic b, input logic fs, input logic bv);
    signal_in   = b;
    frame_start = fs;
    bit_valid   = bv;
    @(posedge CLK);
    #1;
  endtask

  // Sends the first nbits of a frame; checks fire only at the points reached
  task automatic send_frame(input logic [DW-1:0] dyn, input logic [SW-1:0] stat,
                            input bit gap, input int nbits, input logic exp_err,
                            input logic [DW-1:0] exp_dyn, input logic [SW-1:0] exp_stat);
    logic b;
    for (int k = 0; k < nbits; k++) begin
      b = (k < DW) ? dyn[DW-1-k] : stat[SW-1-(k-DW)];
      beat(b, (k == 0), 1'b1);
      if (k == 0) begin
        check("start_err_pulse", 128'(frame_err), 128'(exp_err));
        check("start_busy", 128'(busy), 128'(1));
      end
      if (k == DW-1) begin
        check("dyn_valid_strobe", 128'(dyn_valid), 128'(1));
        check("dynlatch", 128'(DYNLATCH), 128'(exp_dyn));
      end
      if (k == DW+SW-1) begin
        check("frame_valid_strobe", 128'(frame_valid), 128'(1));
        check("statlatch", 128'(STATLATCH), 128'(exp_stat));
        check("busy_after_frame", 128'(busy), 128'(0));
      end
      if (gap) begin
        beat(1'b0, 1'b0, 1'b0);
        if (k == DW-1 || k == DW+SW-1)
          check("no_strobe_on_idle", 128'({dyn_valid, frame_valid}), 128'(0));
      end
    end
  endtask

  typedef struct {
    logic [DW-1:0] dyn;
    logic [SW-1:0] stat;
    bit            gap;
    logic [DW-1:0] exp_dyn;
    logic [SW-1:0] exp_stat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dv0, fv0, fe0;

    vecs[0] = '{16'h1234, 88'hABCDEF123456789ABCDEF1, 1'b0, 16'h1234, 88'hABCDEF123456789ABCDEF1};
    vecs[1] = '{16'h1234, 88'hABCDEF123456789ABCDEF1, 1'b1, 16'h1234, 88'hABCDEF123456789ABCDEF1};
    vecs[2] = '{16'hFFFF, {SW{1'b1}},                 1'b0, 16'hFFFF, {SW{1'b1}}};
    vecs[3] = '{16'h0001, 88'h1,                      1'b0, 16'h0001, 88'h1};

    // Reset state
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    check("reset_outputs", 128'({DYNLATCH, dyn_valid, frame_valid, frame_err, busy}), 128'(0));
    check("reset_stat", 128'(STATLATCH), 128'(0));
    check("reset_errcnt", 128'(err_cnt), 128'(0));

    // Ignored stimuli in IDLE
    dv0 = n_dv; fv0 = n_fv;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 1'b1, 1'b0);
      check("idle_fs_without_valid_busy", 128'(busy), 128'(0));
    end
    for (int i = 0; i < 4; i++) begin
      beat(i[0], 1'b0, 1'b1);
      check("idle_bits_no_start_busy", 128'(busy), 128'(0));
    end
    check("idle_no_strobes", 128'(n_dv - dv0 + n_fv - fv0), 128'(0));

    // Table: single, gapped and back-to-back frames (entries 2,3 are contiguous)
    dv0 = n_dv; fv0 = n_fv;
    for (int i = 0; i < 4; i++)
      send_frame(vecs[i].dyn, vecs[i].stat, vecs[i].gap, DW+SW, 1'b0,
                 vecs[i].exp_dyn, vecs[i].exp_stat);
    beat(1'b0, 1'b0, 1'b0);
    check("table_dv_count", 128'(n_dv - dv0), 128'(4));
    check("table_fv_count", 128'(n_fv - fv0), 128'(4));
    check("table_errcnt", 128'(err_cnt), 128'(0));

    // Abort at static bit 40, then a complete replacement frame
    send_frame(16'hA5A5, 88'hFEDCBA9876543210FEDCBA, 1'b0, DW+40, 1'b0, 16'hA5A5, 88'h0);
    fe0 = n_fe; fv0 = n_fv;
    beat(1'b0, 1'b1, 1'b1);
    check("abort_err_pulse", 128'(frame_err), 128'(1));
    check("abort_errcnt", 128'(err_cnt), 128'(1));
    check("abort_dyn_kept", 128'(DYNLATCH), 128'(16'hA5A5));
    check("abort_stat_kept", 128'(STATLATCH), 128'(88'h1));
    beat(1'b0, 1'b0, 1'b0);
    check("abort_err_one_cycle", 128'(frame_err), 128'(0));
    // Finish the frame begun by the abort beat: dyn 16'h5A5A (MSB 0 already sent)
    for (int k = 1; k < DW+SW; k++) begin
      logic [DW+SW-1:0] w;
      w = {16'h5A5A, 88'h0123456789ABCDEF012345};
      beat(w[DW+SW-1-k], 1'b0, 1'b1);
    end
    check("post_abort_dyn", 128'(DYNLATCH), 128'(16'h5A5A));
    check("post_abort_stat", 128'(STATLATCH), 128'(88'h0123456789ABCDEF012345));
    check("post_abort_fv", 128'(frame_valid), 128'(1));
    check("post_abort_err_pulses", 128'(n_fe - fe0), 128'(1));

    // Reset mid-frame at dynamic bit 8
    send_frame(16'h1234, 88'h0, 1'b0, 8, 1'b0, 16'h0, 88'h0);
    RST = 1'b1;
    beat(1'b1, 1'b0, 1'b1);
    RST = 1'b0;
    check("midreset_outputs", 128'({DYNLATCH, dyn_valid, frame_valid, frame_err, busy}), 128'(0));
    check("midreset_stat", 128'(STATLATCH), 128'(0));
    check("midreset_errcnt", 128'(err_cnt), 128'(0));
    dv0 = n_dv; fv0 = n_fv;
    for (int i = 0; i < 8; i++) beat(1'b1, 1'b0, 1'b1);
    check("midreset_idle", 128'(busy), 128'(0));
    check("midreset_no_strobes", 128'(n_dv - dv0 + n_fv - fv0), 128'(0));

    // Saturation: one start then 260 early starts
    fe0 = n_fe;
    beat(1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 260; i++) begin
      beat(1'b1, 1'b1, 1'b1);
      if (i == 254) check("errcnt_254", 128'(err_cnt), 128'(254));
      if (i == 255) check("errcnt_255", 128'(err_cnt), 128'(255));
    end
    check("errcnt_saturated", 128'(err_cnt), 128'(8'hFF));
    check("busy_during_aborts", 128'(busy), 128'(1));
    beat(1'b0, 1'b0, 1'b0);
    check("abort_pulse_count", 128'(n_fe - fe0), 128'(260));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
